// File: rtl/pkt_byte_writer.sv
// Ping-pong packet writer: streams received bytes into one half of a 2x1024-byte
// buffer and hands each complete, error-free packet to a consumer in arrival order.
module pkt_byte_writer #(
    parameter int MAX_LEN = 1024
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rx_valid_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_last_in,
    input  logic        rx_err_in,
    output logic        bram_en_out,
    output logic        bram_we_out,
    output logic [10:0] bram_addr_out,
    output logic [7:0]  bram_wr_d_out,
    output logic        pkt_ready_out,
    output logic        pkt_half_out,
    output logic [10:0] pkt_len_out,
    input  logic        pkt_done_in,
    output logic [7:0]  drop_cnt_out
);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);

    state_t            state_q, state_d;
    logic [10:0]       cnt_q, cnt_d;
    logic              wr_half_q, wr_half_d;
    logic              rd_half_q, rd_half_d;
    logic [1:0]        full_q, full_d;
    logic [1:0][10:0]  len_q, len_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              we_q, we_d;
    logic [10:0]       addr_q, addr_d;
    logic [7:0]        wd_q, wd_d;
    logic              pend_q, pend_d;
    logic              pend_half_q, pend_half_d;
    logic              commit;
    logic              drop;

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_half_q   <= 1'b0;
            rd_half_q   <= 1'b0;
            full_q      <= '0;
            len_q       <= '0;
            drop_cnt_q  <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wd_q        <= '0;
            pend_q      <= 1'b0;
            pend_half_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_half_q   <= wr_half_d;
            rd_half_q   <= rd_half_d;
            full_q      <= full_d;
            len_q       <= len_d;
            drop_cnt_q  <= drop_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
            pend_q      <= pend_d;
            pend_half_q <= pend_half_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_half_d   = wr_half_q;
        rd_half_d   = rd_half_q;
        full_d      = full_q;
        len_d       = len_q;
        drop_cnt_d  = drop_cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wd_d        = wd_q;
        pend_d      = 1'b0;
        pend_half_d = pend_half_q;
        commit      = 1'b0;
        drop        = 1'b0;

        // A committed half becomes visible one cycle after its last write strobe.
        if (pend_q)
            full_d[pend_half_q] = 1'b1;
        if (pkt_done_in && full_q[rd_half_q]) begin
            full_d[rd_half_q] = 1'b0;
            rd_half_d         = ~rd_half_q;
        end

        if (rx_valid_in) begin
            unique case (state_q)
                IDLE: begin
                    if (!full_q[wr_half_q]) begin
                        we_d   = 1'b1;
                        addr_d = {wr_half_q, 10'd0};
                        wd_d   = rx_data_in;
                        cnt_d  = 11'd1;
                        if (rx_last_in) begin
                            if (rx_err_in) drop   = 1'b1;
                            else           commit = 1'b1;
                        end else begin
                            state_d = RECV;
                        end
                    end else if (rx_last_in) begin
                        drop = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
                RECV: begin
                    if (cnt_q < MAX_LEN_C) begin
                        we_d   = 1'b1;
                        addr_d = {wr_half_q, cnt_q[9:0]};
                        wd_d   = rx_data_in;
                        cnt_d  = cnt_q + 11'd1;
                        if (rx_last_in) begin
                            if (rx_err_in) begin
                                drop    = 1'b1;
                                state_d = IDLE;
                            end else begin
                                commit = 1'b1;
                            end
                        end
                    end else if (rx_last_in) begin
                        drop    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end
                DROP: begin
                    if (rx_last_in) begin
                        drop    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (commit) begin
            len_d[wr_half_q] = cnt_d;
            wr_half_d        = ~wr_half_q;
            pend_d           = 1'b1;
            pend_half_d      = wr_half_q;
            state_d          = IDLE;
        end
        if (drop && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Output logic
    always_comb begin
        bram_en_out   = we_q;
        bram_we_out   = we_q;
        bram_addr_out = addr_q;
        bram_wr_d_out = wd_q;
        pkt_ready_out = full_q[rd_half_q];
        pkt_half_out  = rd_half_q;
        pkt_len_out   = len_q[rd_half_q];
        drop_cnt_out  = drop_cnt_q;
    end

endmodule

// File: tb/tb_pkt_byte_writer.sv
// Directed bench for pkt_byte_writer: ping-pong handoff, drops, oversize,
// error abort, coincident commit/release, async reset and drop-counter saturation.
module tb_pkt_byte_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_last = 1'b0;
    logic        rx_err = 1'b0;
    logic        pkt_done = 1'b0;
    logic        bram_en, bram_we, pkt_ready, pkt_half;
    logic [10:0] bram_addr, pkt_len;
    logic [7:0]  bram_wd, drop_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pkt_byte_writer #(.MAX_LEN(1024)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .rx_valid_in   (rx_valid),
        .rx_data_in    (rx_data),
        .rx_last_in    (rx_last),
        .rx_err_in     (rx_err),
        .bram_en_out   (bram_en),
        .bram_we_out   (bram_we),
        .bram_addr_out (bram_addr),
        .bram_wr_d_out (bram_wd),
        .pkt_ready_out (pkt_ready),
        .pkt_half_out  (pkt_half),
        .pkt_len_out   (pkt_len),
        .pkt_done_in   (pkt_done),
        .drop_cnt_out  (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last, input logic err);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = d; rx_last = last; rx_err = err; pkt_done = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_wr(input string tag, input logic [7:0] d, input logic last,
                           input logic err, input logic [10:0] exp_addr);
        send(d, last, err);
        chk({tag, "_we"}, 32'(bram_we), 32'd1);
        chk({tag, "_en"}, 32'(bram_en), 32'd1);
        chk({tag, "_addr"}, 32'(bram_addr), 32'(exp_addr));
        chk({tag, "_data"}, 32'(bram_wd), 32'(d));
    endtask

    task automatic send_nowr(input string tag, input logic [7:0] d, input logic last);
        send(d, last, 1'b0);
        chk({tag, "_we"}, 32'(bram_we), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; pkt_done = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic done_pulse();
        @(negedge clk);
        rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; pkt_done = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; pkt_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},    32'(bram_en),   0);
        chk({tag, "_we"},    32'(bram_we),   0);
        chk({tag, "_addr"},  32'(bram_addr), 0);
        chk({tag, "_wd"},    32'(bram_wd),   0);
        chk({tag, "_ready"}, 32'(pkt_ready), 0);
        chk({tag, "_half"},  32'(pkt_half),  0);
        chk({tag, "_len"},   32'(pkt_len),   0);
        chk({tag, "_drop"},  32'(drop_cnt),  0);
    endtask

    initial begin
        // Reset state, asserted with no clock edge involved
        #1 rst_n = 1'b0;
        #2 chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single 4-byte packet
        send_wr("p1b0", 8'h11, 1'b0, 1'b0, 11'h000);
        send_wr("p1b1", 8'h22, 1'b0, 1'b0, 11'h001);
        send_wr("p1b2", 8'h33, 1'b0, 1'b0, 11'h002);
        send_wr("p1b3", 8'h44, 1'b1, 1'b0, 11'h003);
        chk("p1_ready_n1", 32'(pkt_ready), 0);
        idle(1);
        chk("p1_we_idle", 32'(bram_we), 0);
        chk("p1_ready_n2", 32'(pkt_ready), 1);
        chk("p1_half", 32'(pkt_half), 0);
        chk("p1_len", 32'(pkt_len), 4);

        // Ping-pong with two 3-byte packets
        do_reset();
        send_wr("ppa0", 8'hA0, 1'b0, 1'b0, 11'h000);
        send_wr("ppa1", 8'hA1, 1'b0, 1'b0, 11'h001);
        send_wr("ppa2", 8'hA2, 1'b1, 1'b0, 11'h002);
        send_wr("ppb0", 8'hB0, 1'b0, 1'b0, 11'h400);
        send_wr("ppb1", 8'hB1, 1'b0, 1'b0, 11'h401);
        send_wr("ppb2", 8'hB2, 1'b1, 1'b0, 11'h402);
        idle(1);
        chk("pp_ready0", 32'(pkt_ready), 1);
        chk("pp_half0", 32'(pkt_half), 0);
        done_pulse();
        chk("pp_ready1", 32'(pkt_ready), 1);
        chk("pp_half1", 32'(pkt_half), 1);
        chk("pp_len1", 32'(pkt_len), 3);
        send_wr("ppc0", 8'hC0, 1'b0, 1'b0, 11'h000);
        send_wr("ppc1", 8'hC1, 1'b0, 1'b0, 11'h001);
        send_wr("ppc2", 8'hC2, 1'b1, 1'b0, 11'h002);
        idle(1);

        // Strobes without valid are ignored
        @(negedge clk);
        rx_valid = 1'b0; rx_last = 1'b1; rx_err = 1'b1;
        @(posedge clk);
        #1;
        chk("novalid_we", 32'(bram_we), 0);
        idle(1);
        chk("novalid_drop", 32'(drop_cnt), 0);

        // Both halves full: 5-byte packet is dropped
        send_nowr("full0", 8'hD0, 1'b0);
        send_nowr("full1", 8'hD1, 1'b0);
        send_nowr("full2", 8'hD2, 1'b0);
        send_nowr("full3", 8'hD3, 1'b0);
        send_nowr("full4", 8'hD4, 1'b1);
        chk("full_drop", 32'(drop_cnt), 1);
        idle(2);
        chk("full_ready", 32'(pkt_ready), 1);
        chk("full_half", 32'(pkt_half), 1);
        done_pulse();
        chk("rel_half0", 32'(pkt_half), 0);
        chk("rel_len0", 32'(pkt_len), 3);
        done_pulse();
        chk("rel_ready", 32'(pkt_ready), 0);
        chk("rel_half1", 32'(pkt_half), 1);
        done_pulse();
        chk("ign_done_half", 32'(pkt_half), 1);
        chk("ign_done_ready", 32'(pkt_ready), 0);

        // Oversize: 1025 bytes -> 1024 writes then drop
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            send(8'(i), 1'b0, 1'b0);
            chk("ovr_we", 32'(bram_we), 1);
            chk("ovr_addr", 32'(bram_addr), 32'(i));
        end
        send_nowr("ovr_last", 8'hAA, 1'b1);
        chk("ovr_drop", 32'(drop_cnt), 1);
        idle(2);
        chk("ovr_ready", 32'(pkt_ready), 0);

        // Exactly MAX_LEN bytes commits
        for (int i = 0; i < 1024; i++) begin
            send(8'(i + 3), (i == 1023), 1'b0);
            chk("max_we", 32'(bram_we), 1);
            chk("max_addr", 32'(bram_addr), 32'(i));
        end
        idle(1);
        chk("max_ready", 32'(pkt_ready), 1);
        chk("max_half", 32'(pkt_half), 0);
        chk("max_len", 32'(pkt_len), 1024);

        // Error on last byte aborts; the half stays free
        send_wr("err0", 8'h5A, 1'b0, 1'b0, 11'h400);
        send(8'hA5, 1'b1, 1'b1);
        chk("err_drop", 32'(drop_cnt), 2);
        idle(2);
        chk("err_half", 32'(pkt_half), 0);
        chk("err_len", 32'(pkt_len), 1024);

        // 1-byte packet into the freed half, committing as half 0 is released
        send_wr("one", 8'h77, 1'b1, 1'b0, 11'h400);
        done_pulse();
        chk("coin_ready", 32'(pkt_ready), 1);
        chk("coin_half", 32'(pkt_half), 1);
        chk("coin_len", 32'(pkt_len), 1);
        done_pulse();
        chk("coin_ready2", 32'(pkt_ready), 0);
        chk("coin_half2", 32'(pkt_half), 0);

        // Reset in the middle of a packet
        send_wr("mr0", 8'h01, 1'b0, 1'b0, 11'h000);
        send_wr("mr1", 8'h02, 1'b0, 1'b0, 11'h001);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n = 1'b1;
        send_wr("post", 8'h99, 1'b1, 1'b0, 11'h000);
        chk("post_drop", 32'(drop_cnt), 0);
        idle(1);
        chk("post_ready", 32'(pkt_ready), 1);
        chk("post_len", 32'(pkt_len), 1);

        // Drop counter saturation with 300 error packets
        for (int i = 0; i < 300; i++) begin
            send(8'(i), 1'b1, 1'b1);
            if (i == 253) chk("sat_254", 32'(drop_cnt), 254);
            if (i == 254) chk("sat_255", 32'(drop_cnt), 255);
        end
        chk("sat_300", 32'(drop_cnt), 255);
        idle(2);
        chk("sat_ready", 32'(pkt_ready), 1);
        chk("sat_half", 32'(pkt_half), 0);
        chk("sat_len", 32'(pkt_len), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
